hand_requester: RTL

Requester-side partner of the card dealer in the poker datapath. On a `start` pulse it asks the dealer to reshuffle, waits for the shuffle to complete, then pulls `HAND_SIZE` cards one at a time over the `next_card`/`card_valid` four-phase handshake. It stores the cards in slot order for the hand evaluator and VGA renderer, and flags malformed card codes.

---
 rtl/poker_pkg.sv | 43 ++++
 rtl/hand_req_watchdog.sv | 46 ++++
 rtl/hand_requester.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/poker_pkg.sv
// poker_pkg
// Shared definitions for the poker datapath: card encoding, rank bounds,
// suit encodings, hand storage geometry and the hand requester state enum.
// The ERROR state only exists when HAND_REQ_TIMEOUT_EN is defined.
package poker_pkg;

    // A card is [5:4] suit, [3:0] rank (2..14, ace high).
    localparam int CARD_W   = 6;
    localparam int RANK_MIN = 2;
    localparam int RANK_MAX = 14;

    // Hand storage is sized for the largest legal hand.
    localparam int MAX_SLOTS = 8;
    localparam int HAND_W    = MAX_SLOTS * CARD_W;

    typedef enum logic [1:0] {
        SUIT_CLUBS    = 2'd0,
        SUIT_DIAMONDS = 2'd1,
        SUIT_HEARTS   = 2'd2,
        SUIT_SPADES   = 2'd3
    } suit_e;

    typedef enum logic [2:0] {
        REQ_IDLE         = 3'd0,
        REQ_RESHUFFLE    = 3'd1,
        REQ_WAIT_SHUFFLE = 3'd2,
        REQ_GAP          = 3'd3,
        REQ_REQUEST      = 3'd4,
        REQ_RELEASE      = 3'd5,
`ifdef HAND_REQ_TIMEOUT_EN
        REQ_DONE         = 3'd6,
        REQ_ERROR        = 3'd7
`else
        REQ_DONE         = 3'd6
`endif
    } req_state_e;

    // Rank check only; the suit field can never be malformed.
    function automatic logic rank_is_bad(input logic [CARD_W-1:0] c);
        return (c[3:0] < 4'(RANK_MIN)) || (c[3:0] > 4'(RANK_MAX));
    endfunction

endpackage

// File: rtl/hand_req_watchdog.sv
// hand_req_watchdog
// Cycle counter used to detect a dealer that stops responding.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     zero the count (takes priority over enable)
//   enable    count one cycle
//   expired   high while enabled and the count has reached LIMIT-1, i.e.
//             on the LIMIT-th consecutive enabled cycle
module hand_req_watchdog
    import poker_pkg::*;
#(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = enable && (count_q >= CNT_W'(LIMIT - 1));

    // Count holds once expired so it can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hand_requester.sv
// hand_requester
// Requester side of the card dealer handshake. On start it asks the dealer
// to reshuffle, waits for a fresh shuffle-complete, then pulls HAND_SIZE
// cards over the four-phase next_card/card_valid handshake and stores them
// in slot order. Malformed ranks raise a sticky card_err.
// Optional feature: define HAND_REQ_TIMEOUT_EN to add a watchdog that moves
// the FSM to an ERROR state after TIMEOUT_CYCLES stuck cycles.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin a new hand (accepted in IDLE, DONE, ERROR)
//   new_hand     reshuffle request to dealer (one cycle)
//   shuffled     dealer shuffle-complete status
//   next_card    card request to dealer
//   card         dealt card, card_valid its acknowledge
//   hand         slot i at [6i+5:6i], unused slots 0
//   hand_count   cards captured so far
//   card_strobe  one-cycle pulse after each capture
//   busy         hand in progress
//   hand_done    level, high in DONE
//   card_err     sticky bad-rank flag
//   timeout_err  watchdog fired (0 without the macro)
module hand_requester
    import poker_pkg::*;
#(
    parameter int HAND_SIZE      = 7,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  new_hand,
    input  logic                  shuffled,
    output logic                  next_card,
    input  logic [CARD_W-1:0]     card,
    input  logic                  card_valid,
    output logic [HAND_W-1:0]     hand,
    output logic [3:0]            hand_count,
    output logic                  card_strobe,
    output logic                  busy,
    output logic                  hand_done,
    output logic                  card_err,
    output logic                  timeout_err
);

    localparam logic [3:0] HAND_SIZE_C = 4'(HAND_SIZE);

    if (HAND_SIZE < 1 || HAND_SIZE > MAX_SLOTS || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("hand_requester: illegal HAND_SIZE or TIMEOUT_CYCLES");
    end

    req_state_e         state_q;
    req_state_e         state_d;
    logic [HAND_W-1:0]  hand_q;
    logic [HAND_W-1:0]  hand_d;
    logic [3:0]         count_q;
    logic [3:0]         count_d;
    logic               strobe_q;
    logic               strobe_d;
    logic               err_q;
    logic               err_d;
    logic               seen_low_q;
    logic               seen_low_d;
    logic               restart;

`ifdef HAND_REQ_TIMEOUT_EN
    logic wd_enable;
    logic wd_clear;
    logic wd_expired;

    // Only the states that wait on the dealer are watched; any state change
    // restarts the count so each wait gets the full budget.
    assign wd_enable = (state_q == REQ_WAIT_SHUFFLE) || (state_q == REQ_REQUEST) ||
                       (state_q == REQ_RELEASE);
    assign wd_clear  = (state_d != state_q);

    hand_req_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`endif

    // Next-state and datapath logic. A restart wipes the previous hand and
    // the shuffle tracking so a stale shuffled level cannot be reused.
    always_comb begin
        state_d    = state_q;
        hand_d     = hand_q;
        count_d    = count_q;
        strobe_d   = 1'b0;
        err_d      = err_q;
        seen_low_d = seen_low_q;
        restart    = 1'b0;

        case (state_q)
            REQ_IDLE, REQ_DONE: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = REQ_RESHUFFLE;
                end
            end
`ifdef HAND_REQ_TIMEOUT_EN
            REQ_ERROR: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = REQ_RESHUFFLE;
                end
            end
`endif
            REQ_RESHUFFLE: begin
                state_d = REQ_WAIT_SHUFFLE;
            end
            REQ_WAIT_SHUFFLE: begin
                if (!shuffled) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = REQ_GAP;
                end
            end
            REQ_GAP: begin
                state_d = REQ_REQUEST;
            end
            REQ_REQUEST: begin
                if (card_valid) begin
                    for (int i = 0; i < MAX_SLOTS; i++) begin
                        if (i < HAND_SIZE && count_q == 4'(i)) begin
                            hand_d[i*CARD_W +: CARD_W] = card;
                        end
                    end
                    if (count_q != HAND_SIZE_C) begin
                        count_d = count_q + 4'd1;
                    end
                    if (rank_is_bad(card)) begin
                        err_d = 1'b1;
                    end
                    strobe_d = 1'b1;
                    state_d  = REQ_RELEASE;
                end
            end
            REQ_RELEASE: begin
                if (!card_valid) begin
                    state_d = (count_q == HAND_SIZE_C) ? REQ_DONE : REQ_GAP;
                end
            end
            default: begin
                state_d = REQ_IDLE;
            end
        endcase

        if (restart) begin
            hand_d     = '0;
            count_d    = '0;
            err_d      = 1'b0;
            seen_low_d = 1'b0;
        end

`ifdef HAND_REQ_TIMEOUT_EN
        // A timeout abandons the wait; nothing captured in that cycle counts.
        if (wd_expired) begin
            state_d  = REQ_ERROR;
            hand_d   = hand_q;
            count_d  = count_q;
            strobe_d = 1'b0;
            err_d    = err_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ_IDLE;
            hand_q     <= '0;
            count_q    <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hand_q     <= hand_d;
            count_q    <= count_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            seen_low_q <= seen_low_d;
        end
    end

    // Handshake outputs decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign new_hand    = (state_q == REQ_RESHUFFLE);
    assign next_card   = (state_q == REQ_REQUEST);
    assign hand_done   = (state_q == REQ_DONE);
    assign busy        = (state_q == REQ_RESHUFFLE) || (state_q == REQ_WAIT_SHUFFLE) ||
                         (state_q == REQ_GAP) || (state_q == REQ_REQUEST) ||
                         (state_q == REQ_RELEASE);
    assign hand        = hand_q;
    assign hand_count  = count_q;
    assign card_strobe = strobe_q;
    assign card_err    = err_q;
`ifdef HAND_REQ_TIMEOUT_EN
    assign timeout_err = (state_q == REQ_ERROR);
`else
    assign timeout_err = 1'b0;
`endif

endmodule
